// File: rtl/multicycle_controller_pkg.sv
// Shared control encodings for the multicycle controller.
// States, opcodes, aluop/alucontrol codes and datapath select values.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder driven by aluop and instruction funct fields.
// funct_ok flags the funct3 values the ALU can actually execute.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);

  assign funct_ok = (funct3 == 3'b000)
                 || (funct3 == 3'b110)
                 || (funct3 == 3'b111);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: per-state datapath selects and strobes.
// Define MULTICYCLE_CTRL_JAL_EN to compile in jal support.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  if (XLEN < 32) begin : g_xlen_chk
    $error("XLEN below 32");
  end

  state_t     state;
  state_t     state_nx;
  logic [1:0] aluop;
  logic       funct_ok;
  logic       dec_bad;

  alu_decoder u_alu_dec (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol),
    .funct_ok   (funct_ok)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    dec_bad = 1'b1;
    case (op)
      OP_LW, OP_SW, OP_BEQ: dec_bad = 1'b0;
      OP_R, OP_I:           dec_bad = !funct_ok;
`ifdef MULTICYCLE_CTRL_JAL_EN
      OP_JAL:               dec_bad = 1'b0;
`endif
      default:              dec_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        if (dec_bad) state_nx = S_FETCH;
        else begin
          case (op)
            OP_LW, OP_SW: state_nx = S_MEMADR;
            OP_R:         state_nx = S_EXECUTER;
            OP_I:         state_nx = S_EXECUTEI;
            OP_BEQ:       state_nx = S_BEQ;
`ifdef MULTICYCLE_CTRL_JAL_EN
            OP_JAL:       state_nx = S_JAL;
`endif
            default:      state_nx = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_nx = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nx = S_MEMWB;
      S_EXECUTER: state_nx = S_ALUWB;
      S_EXECUTEI: state_nx = S_ALUWB;
`ifdef MULTICYCLE_CTRL_JAL_EN
      S_JAL:      state_nx = S_ALUWB;
`endif
      default:    state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_SW:   immsrc = IMM_S;
      OP_BEQ:  immsrc = IMM_B;
      OP_JAL:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

  always_comb begin
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    resultsrc = RES_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        irwrite   = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        illegal = dec_bad;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: regwrite = 1'b1;
      S_BEQ: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        pcwrite = zero;
      end
`ifdef MULTICYCLE_CTRL_JAL_EN
      S_JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
      end
`endif
      default: ;
    endcase
    // Reset wins: abort the instruction, show FETCH selects, no strobes.
    if (!rst_n) begin
      pcwrite   = 1'b0;
      adrsrc    = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      illegal   = 1'b0;
      resultsrc = RES_ALU;
      alusrca   = SRCA_PC;
      alusrcb   = SRCB_FOUR;
      aluop     = ALUOP_ADD;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller.
// Follows MULTICYCLE_CTRL_JAL_EN to pick the expected jal behaviour.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } out_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  out_t       act;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pcwrite    (act.pcwrite),
    .adrsrc     (act.adrsrc),
    .memwrite   (act.memwrite),
    .irwrite    (act.irwrite),
    .regwrite   (act.regwrite),
    .resultsrc  (act.resultsrc),
    .alusrca    (act.alusrca),
    .alusrcb    (act.alusrcb),
    .immsrc     (act.immsrc),
    .alucontrol (act.alucontrol),
    .illegal    (act.illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  function automatic out_t mk(
    logic pw, logic ad, logic mw, logic iw, logic rw,
    logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
    logic [1:0] im, logic [2:0] al, logic il);
    out_t o;
    o = '{pw, ad, mw, iw, rw, rs, sa, sb, im, al, il};
    return o;
  endfunction

  function automatic out_t e_fetch(logic [1:0] im);
    return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0);
  endfunction
  function automatic out_t e_decode(logic [1:0] im, logic il);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, il);
  endfunction
  function automatic out_t e_memadr(logic [1:0] im);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0);
  endfunction
  function automatic out_t e_memread();
    return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic out_t e_memwb();
    return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic out_t e_memwrite();
    return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
  endfunction
  function automatic out_t e_exer(logic [2:0] al);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, al, 0);
  endfunction
  function automatic out_t e_exei(logic [2:0] al);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, al, 0);
  endfunction
  function automatic out_t e_aluwb(logic [1:0] im);
    return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
  endfunction
  function automatic out_t e_beq(logic z);
    return mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
  endfunction
  function automatic out_t e_jal();
    return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
  endfunction
  function automatic out_t e_rst(logic [1:0] im);
    return mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0);
  endfunction

  task automatic add(string nm, logic r, logic [6:0] o, logic [2:0] f3,
                     logic f7, logic z, out_t e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.op = o; v.funct3 = f3;
    v.funct7b5 = f7; v.zero = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(string nm, out_t e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, e);
    end
  endtask

  task automatic check1(string nm, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  initial begin
    add("rst",       0, RT, 3'b000, 1, 0, e_rst(2'b00));
    add("sub_fetch", 1, RT, 3'b000, 1, 0, e_fetch(2'b00));
    add("sub_dec",   1, RT, 3'b000, 1, 0, e_decode(2'b00, 0));
    add("sub_exe",   1, RT, 3'b000, 1, 0, e_exer(3'b001));
    add("sub_wb",    1, RT, 3'b000, 1, 0, e_aluwb(2'b00));
    add("and_fetch", 1, RT, 3'b111, 0, 0, e_fetch(2'b00));
    add("and_dec",   1, RT, 3'b111, 0, 0, e_decode(2'b00, 0));
    add("and_exe",   1, RT, 3'b111, 0, 0, e_exer(3'b010));
    add("and_wb",    1, RT, 3'b111, 0, 0, e_aluwb(2'b00));
    add("lw_fetch",  1, LW, 3'b010, 0, 0, e_fetch(2'b00));
    add("lw_dec",    1, LW, 3'b010, 0, 0, e_decode(2'b00, 0));
    add("lw_adr",    1, LW, 3'b010, 0, 0, e_memadr(2'b00));
    add("lw_rd",     1, LW, 3'b010, 0, 0, e_memread());
    add("lw_wb",     1, LW, 3'b010, 0, 0, e_memwb());
    add("beq1_f",    1, BEQ, 3'b000, 0, 1, e_fetch(2'b10));
    add("beq1_d",    1, BEQ, 3'b000, 0, 1, e_decode(2'b10, 0));
    add("beq1_x",    1, BEQ, 3'b000, 0, 1, e_beq(1));
    add("beq0_f",    1, BEQ, 3'b000, 0, 0, e_fetch(2'b10));
    add("beq0_d",    1, BEQ, 3'b000, 0, 0, e_decode(2'b10, 0));
    add("beq0_x",    1, BEQ, 3'b000, 0, 0, e_beq(0));
    add("ori_f",     1, IT, 3'b110, 0, 0, e_fetch(2'b00));
    add("ori_d",     1, IT, 3'b110, 0, 0, e_decode(2'b00, 0));
    add("ori_x",     1, IT, 3'b110, 0, 0, e_exei(3'b011));
    add("ori_wb",    1, IT, 3'b110, 0, 0, e_aluwb(2'b00));
    add("addi7_f",   1, IT, 3'b000, 1, 0, e_fetch(2'b00));
    add("addi7_d",   1, IT, 3'b000, 1, 0, e_decode(2'b00, 0));
    add("addi7_x",   1, IT, 3'b000, 1, 0, e_exei(3'b000));
    add("addi7_wb",  1, IT, 3'b000, 1, 0, e_aluwb(2'b00));
    add("ibad_f",    1, IT, 3'b010, 0, 0, e_fetch(2'b00));
    add("ibad_d",    1, IT, 3'b010, 0, 0, e_decode(2'b00, 1));
    add("ibad_back", 1, IT, 3'b010, 0, 0, e_fetch(2'b00));
    add("opbad_d",   1, 7'b0000000, 3'b000, 0, 0, e_decode(2'b00, 1));
    add("jal_f",     1, JAL, 3'b000, 0, 0, e_fetch(2'b11));
`ifdef MULTICYCLE_CTRL_JAL_EN
    add("jal_d",     1, JAL, 3'b000, 0, 0, e_decode(2'b11, 0));
    add("jal_x",     1, JAL, 3'b000, 0, 0, e_jal());
    add("jal_wb",    1, JAL, 3'b000, 0, 0, e_aluwb(2'b11));
`else
    add("jal_d",     1, JAL, 3'b000, 0, 0, e_decode(2'b11, 1));
`endif
    add("sw_f",      1, SW, 3'b010, 0, 0, e_fetch(2'b01));
    add("sw_d",      1, SW, 3'b010, 0, 0, e_decode(2'b01, 0));
    add("sw_adr",    1, SW, 3'b010, 0, 0, e_memadr(2'b01));
    add("sw_rst",    0, SW, 3'b010, 0, 0, e_rst(2'b01));
    add("sw_rel",    1, SW, 3'b010, 0, 0, e_fetch(2'b01));
    add("sw2_d",     1, SW, 3'b010, 0, 0, e_decode(2'b01, 0));
    add("sw2_adr",   1, SW, 3'b010, 0, 0, e_memadr(2'b01));
    add("sw2_wr",    1, SW, 3'b010, 0, 0, e_memwrite());
    add("sw2_back",  1, SW, 3'b010, 0, 0, e_fetch(2'b01));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n    = vecs[i].rst_n;
      op       = vecs[i].op;
      funct3   = vecs[i].funct3;
      funct7b5 = vecs[i].funct7b5;
      zero     = vecs[i].zero;
      #1;
      check(vecs[i].name, vecs[i].exp);
    end

    // pcwrite in BEQ follows zero within the cycle
    @(negedge clk);
    rst_n = 1'b0; op = BEQ; funct3 = 3'b000; zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("hs_fetch", e_fetch(2'b10));
    @(negedge clk);
    #1 check("hs_dec", e_decode(2'b10, 0));
    @(negedge clk);
    zero = 1'b1;
    #1 check1("hs_beq_z1", act.pcwrite, 1'b1);
    zero = 1'b0;
    #1 check1("hs_beq_z0", act.pcwrite, 1'b0);
    check1("hs_beq_sub", act.alucontrol == 3'b001, 1'b1);

    // reset during EXECUTER: selects forced, alucontrol back to add
    @(negedge clk);
    op = RT; funct3 = 3'b000; funct7b5 = 1'b1;
    #1 check("hs_r_fetch", e_fetch(2'b00));
    @(negedge clk);
    #1 check("hs_r_dec", e_decode(2'b00, 0));
    @(negedge clk);
    #1 check("hs_r_exe", e_exer(3'b001));
    rst_n = 1'b0;
    #1 check("hs_r_rst", e_rst(2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("hs_r_after", e_fetch(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
